// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: serialises queued bytes onto open-drain clk/data drives.
// Optional build macro PS2_TX_FIFO_EN selects a FIFO_DEPTH-entry byte FIFO instead of one register.
module ps2_device_tx #(
  parameter int unsigned CLK_HZ     = 28000000,
  parameter int unsigned PS2_HZ     = 12500,
  parameter int unsigned GAP_US     = 50,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       ps2_clk_out,
  output logic       ps2_data_out,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       busy,
  output logic       host_req,
  output logic       overflow
);

  localparam int unsigned HalfCycles = CLK_HZ / (2 * PS2_HZ);
  localparam int unsigned GapCycles  = 32'((64'(GAP_US) * 64'(CLK_HZ)) / 64'd1000000);
  localparam int unsigned CntMax     = (GapCycles > HalfCycles) ? GapCycles : HalfCycles;
  localparam int unsigned CntW       = $clog2(CntMax + 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StWaitGap = 2'd1;
  localparam logic [1:0] StShift   = 2'd2;
  localparam logic [1:0] StGap     = 2'd3;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || HalfCycles < 1 ||
      GapCycles < 1) begin : g_param_check
    $error("ps2_device_tx: FIFO_DEPTH must be a power of two >= 2 and timings non-zero");
  end

  logic       push;
  logic       pop;
  logic       pending;
  logic [7:0] head;

  assign push = tx_valid & tx_ready;

`ifdef PS2_TX_FIFO_EN
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            full;

  assign full     = (count_q == (PtrW + 1)'(FIFO_DEPTH));
  assign pending  = (count_q != '0);
  assign head     = mem_q[rd_ptr_q];
  assign tx_ready = ~full;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end
`else
  logic [7:0] hold_q;
  logic       hold_valid_q;

  assign pending  = hold_valid_q;
  assign head     = hold_q;
  assign tx_ready = ~hold_valid_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      hold_q       <= 8'h00;
    end else begin
      if (push) begin
        hold_valid_q <= 1'b1;
        hold_q       <= tx_data;
      end else if (pop) begin
        hold_valid_q <= 1'b0;
      end
    end
  end
`endif

  logic [1:0]      clk_sync_q;
  logic [1:0]      data_sync_q;
  logic            clk_s;
  logic            data_s;
  logic            lines_high;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic            low_phase_q, low_phase_d;
  logic            clk_out_q, clk_out_d;
  logic            data_out_q, data_out_d;
  logic            clk_low_prev_q, clk_low_prev_d;
  logic            host_req_q, host_req_d;
  logic            overflow_q, overflow_d;

  logic            listening;
  logic            req_det;
  logic [10:0]     frame;

  assign clk_s      = clk_sync_q[1];
  assign data_s     = data_sync_q[1];
  assign lines_high = clk_s & data_s;

  // Frame bit order on the wire: start, data LSB first, odd parity, stop.
  assign frame = {1'b1, ~^head, head, 1'b0};

  assign listening = (state_q == StIdle) || (state_q == StWaitGap);
  // Host request: clock was low last cycle and is now released while data is held low.
  assign req_det   = listening && clk_low_prev_q && clk_s && !data_s;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bit_d          = bit_q;
    low_phase_d    = low_phase_q;
    clk_out_d      = clk_out_q;
    data_out_d     = data_out_q;
    clk_low_prev_d = listening ? ~clk_s : 1'b0;
    host_req_d     = req_det;
    overflow_d     = overflow_q | (tx_valid & ~tx_ready);
    pop            = 1'b0;

    case (state_q)
      StIdle: begin
        if (pending || req_det) begin
          state_d = StWaitGap;
          cnt_d   = '0;
        end
      end

      StWaitGap: begin
        if (!lines_high) begin
          cnt_d = '0;
        end else if (cnt_q == CntW'(GapCycles - 1)) begin
          cnt_d = '0;
          if (pending) begin
            state_d     = StShift;
            bit_d       = 4'd0;
            low_phase_d = 1'b0;
            clk_out_d   = 1'b1;
            data_out_d  = frame[0];
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StShift: begin
        // Host grabbing the clock before the parity low phase aborts; the byte stays queued.
        if (!low_phase_q && !clk_s && (bit_q <= 4'd9)) begin
          state_d     = StWaitGap;
          cnt_d       = '0;
          low_phase_d = 1'b0;
          clk_out_d   = 1'b1;
          data_out_d  = 1'b1;
        end else if (cnt_q == CntW'(HalfCycles - 1)) begin
          cnt_d = '0;
          if (!low_phase_q) begin
            low_phase_d = 1'b1;
            clk_out_d   = 1'b0;
          end else begin
            low_phase_d = 1'b0;
            clk_out_d   = 1'b1;
            if (bit_q == 4'd10) begin
              state_d    = StGap;
              data_out_d = 1'b1;
            end else begin
              bit_d      = bit_q + 4'd1;
              data_out_d = frame[bit_q + 4'd1];
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StGap: begin
        pop        = 1'b1;
        clk_out_d  = 1'b1;
        data_out_d = 1'b1;
        cnt_d      = '0;
        state_d    = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_sync_q     <= 2'b11;
      data_sync_q    <= 2'b11;
      state_q        <= StIdle;
      cnt_q          <= '0;
      bit_q          <= 4'd0;
      low_phase_q    <= 1'b0;
      clk_out_q      <= 1'b1;
      data_out_q     <= 1'b1;
      clk_low_prev_q <= 1'b0;
      host_req_q     <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      clk_sync_q     <= {clk_sync_q[0], ps2_clk_in};
      data_sync_q    <= {data_sync_q[0], ps2_data_in};
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_q          <= bit_d;
      low_phase_q    <= low_phase_d;
      clk_out_q      <= clk_out_d;
      data_out_q     <= data_out_d;
      clk_low_prev_q <= clk_low_prev_d;
      host_req_q     <= host_req_d;
      overflow_q     <= overflow_d;
    end
  end

  assign ps2_clk_out  = clk_out_q;
  assign ps2_data_out = data_out_q;
  assign busy         = (state_q != StIdle) | pending;
  assign host_req     = host_req_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx: random and directed bytes decoded by a host-side receiver model.
module tb_ps2_device_tx;

  localparam int unsigned TbClkHz = 1000000;
  localparam int unsigned TbPs2Hz = 50000;
  localparam int unsigned TbGapUs = 20;
  localparam int unsigned Half    = TbClkHz / (2 * TbPs2Hz);
  localparam int unsigned Gap     = TbGapUs * (TbClkHz / 1000000);
`ifdef PS2_TX_FIFO_EN
  localparam int unsigned Cap = 8;
`else
  localparam int unsigned Cap = 1;
`endif

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_out;
  logic       ps2_data_out;
  logic       host_clk = 1'b1;
  logic       host_data = 1'b1;
  logic       busy;
  logic       host_req;
  logic       overflow;

  ps2_device_tx #(
    .CLK_HZ    (TbClkHz),
    .PS2_HZ    (TbPs2Hz),
    .GAP_US    (TbGapUs),
    .FIFO_DEPTH(8)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_out (ps2_clk_out),
    .ps2_data_out(ps2_data_out),
    .ps2_clk_in  (host_clk),
    .ps2_data_in (host_data),
    .busy        (busy),
    .host_req    (host_req),
    .overflow    (overflow)
  );

  initial forever #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Expected bytes with the cycle each was accepted.
  logic [7:0] exp_q[$];
  int         acc_q[$];

  // Host-side receiver model on the wired-AND lines.
  int   cyc = 0;
  bit   rx_bits[$];
  bit   prev_cl = 1'b1;
  bit   prev_dl = 1'b1;
  bit   prev_dev_clk = 1'b1;
  bit   mon_cl;
  bit   mon_dl;
  int   fall_cyc = 0;
  int   start_cyc = 0;
  int   start_quiet = 0;
  int   last_low_cyc = 0;
  int   req_pulses = 0;
  int   dev_falls = 0;
  int   rx_count = 0;
  logic last_parity = 1'b0;

  task automatic finish_frame();
    logic [7:0] b;
    logic [8:0] pv;
    for (int i = 0; i < 9; i++) pv[i] = rx_bits[i + 1];
    b = pv[7:0];
    check_eq("start_bit", 32'(rx_bits[0]), 0);
    check_eq("stop_bit", 32'(rx_bits[10]), 1);
    check_eq("parity_odd", 32'($countones(pv) % 2), 1);
    check_eq("frame_len", cyc - start_cyc, 22 * Half);
    check_eq("quiet_gap", 32'(start_quiet > int'(Gap)), 1);
    check_eq("frame_expected", 32'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      check_eq("rx_byte", 32'(b), 32'(exp_q[0]));
      check_eq("accept_gap", 32'((start_cyc - acc_q[0]) >= int'(Gap)), 1);
      void'(exp_q.pop_front());
      void'(acc_q.pop_front());
    end
    last_parity = pv[8];
    rx_count++;
  endtask

  always @(negedge clk_sys) begin
    mon_cl = ps2_clk_out & host_clk;
    mon_dl = ps2_data_out & host_data;
    cyc++;
    if (cyc > 90000) begin
      $display("FAIL watchdog: cycle budget exhausted at %0d", cyc);
      $fatal(1, "watchdog");
    end
    if (host_req) req_pulses++;
    if (prev_dev_clk && !ps2_clk_out) dev_falls++;
    if (reset || !host_clk) begin
      rx_bits.delete();
    end else begin
      if (prev_dl && !mon_dl && mon_cl && rx_bits.size() == 0) begin
        start_cyc   = cyc;
        start_quiet = cyc - last_low_cyc;
      end
      if (prev_cl && !mon_cl) begin
        rx_bits.push_back(mon_dl);
        fall_cyc = cyc;
      end
      if (!prev_cl && mon_cl && rx_bits.size() > 0) begin
        check_eq("clk_low", cyc - fall_cyc, Half);
        if (rx_bits.size() == 11) begin
          finish_frame();
          rx_bits.delete();
        end
      end
    end
    if (!(mon_cl && mon_dl)) last_low_cyc = cyc;
    prev_cl      = mon_cl;
    prev_dl      = mon_dl;
    prev_dev_clk = ps2_clk_out;
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!tx_ready && n < 3000) begin
      tick();
      n++;
    end
    check_eq("tx_ready_wait", 32'(tx_ready), 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk_sys);
    exp_q.push_back(b);
    acc_q.push_back(cyc);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      tick();
      n++;
    end
    check_eq("drain", 32'(exp_q.size() == 0 && !busy), 1);
  endtask

  initial begin
    int rx0;
    int req0;
    int f0;
    int n;
    logic [7:0] rb;

    repeat (4) tick();
    check_eq("rst_clk", 32'(ps2_clk_out), 1);
    check_eq("rst_data", 32'(ps2_data_out), 1);
    check_eq("rst_ready", 32'(tx_ready), 1);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_hreq", 32'(host_req), 0);
    check_eq("rst_ovf", 32'(overflow), 0);
    reset = 1'b0;
    repeat (3) tick();

    send_byte(8'h1C);
    wait_drain();
    check_eq("parity_1c", 32'(last_parity), 0);
    send_byte(8'h00);
    wait_drain();
    check_eq("parity_00", 32'(last_parity), 1);

    rx0 = rx_count;
    send_byte(8'hF0);
    send_byte(8'h1C);
    wait_drain();
    check_eq("b2b_count", rx_count - rx0, 2);

    // Host inhibit before and during the request.
    req0     = req_pulses;
    host_clk = 1'b0;
    repeat (10) tick();
    f0 = dev_falls;
    send_byte(8'hA5);
    repeat (90) tick();
    check_eq("inhibit_no_clk", dev_falls - f0, 0);
    check_eq("inhibit_busy", 32'(busy), 1);
    host_clk = 1'b1;
    wait_drain();
    check_eq("inhibit_no_req", req_pulses - req0, 0);

    // Host-to-device request from idle.
    req0     = req_pulses;
    host_clk = 1'b0;
    repeat (20) tick();
    host_data = 1'b0;
    repeat (5) tick();
    host_clk = 1'b1;
    repeat (10) tick();
    f0 = dev_falls;
    send_byte(8'h33);
    repeat (40) tick();
    check_eq("hreq_once", req_pulses - req0, 1);
    check_eq("hreq_hold", dev_falls - f0, 0);
    host_data = 1'b1;
    wait_drain();
    check_eq("hreq_total", req_pulses - req0, 1);

    // Collision during data bit 3, then full retransmit.
    rx0 = rx_count;
    send_byte(8'h5A);
    n = 0;
    while (!(rx_bits.size() == 3 && ps2_clk_out) && n < 2000) begin
      tick();
      n++;
    end
    check_eq("reach_bit3", 32'(rx_bits.size() == 3 && ps2_clk_out), 1);
    repeat (2) tick();
    host_clk = 1'b0;
    repeat (3) tick();
    check_eq("abort_clk_rel", 32'(ps2_clk_out), 1);
    check_eq("abort_data_rel", 32'(ps2_data_out), 1);
    check_eq("abort_busy", 32'(busy), 1);
    check_eq("abort_ready", 32'(tx_ready), (Cap == 1) ? 0 : 1);
    repeat (40) tick();
    check_eq("abort_held", 32'(busy && ps2_clk_out && ps2_data_out), 1);
    host_clk = 1'b1;
    wait_drain();
    check_eq("retx_count", rx_count - rx0, 1);

    // Randomized bytes with random spacing.
    rx0 = rx_count;
    for (int i = 0; i < 10; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_byte(rb);
      if ($urandom_range(0, 3) == 0) wait_drain();
      else repeat ($urandom_range(0, 15)) tick();
    end
    wait_drain();
    check_eq("rand_count", rx_count - rx0, 10);

    // Fill storage while inhibited, overflow, then reset mid-frame.
    host_clk = 1'b0;
    repeat (5) tick();
    for (int i = 0; i < int'(Cap); i++) send_byte(8'($urandom_range(0, 255)));
    tick();
    check_eq("full_ready", 32'(tx_ready), 0);
    check_eq("ovf_before", 32'(overflow), 0);
    tx_data  = 8'hEE;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    check_eq("ovf_set", 32'(overflow), 1);
    host_clk = 1'b1;
    n = 0;
    while (rx_bits.size() < 2 && n < 3000) begin
      tick();
      n++;
    end
    check_eq("reach_mid", 32'(rx_bits.size() >= 2), 1);
    reset = 1'b1;
    tick();
    check_eq("mid_rst_clk", 32'(ps2_clk_out), 1);
    check_eq("mid_rst_data", 32'(ps2_data_out), 1);
    check_eq("mid_rst_busy", 32'(busy), 0);
    check_eq("mid_rst_ready", 32'(tx_ready), 1);
    check_eq("mid_rst_ovf", 32'(overflow), 0);
    reset = 1'b0;
    exp_q.delete();
    acc_q.delete();
    rx0 = rx_count;
    repeat (300) tick();
    check_eq("post_rst_no_frame", rx_count - rx0, 0);
    check_eq("post_rst_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
